mc_alu: RTL and testbench



---
 rtl/mc_alu.sv | 142 ++++++++++++++
 tb/tb_mc_alu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU with built-in ALU-control decode; 1-cycle ops, WIDTH-cycle shift-add multiply.
// Latency 1 (MUL: WIDTH); no queueing, start ignored while ready=0, ready returns the cycle after done.
module mc_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MUL,
        OP_ILL
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MULT
    } state_t;

    state_t           state;
    op_t              dec_op;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    always_comb begin
        dec_op = OP_ILL;
        case (aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b011000: dec_op = MUL_EN ? OP_MUL : OP_ILL;
                    default:   dec_op = OP_ILL;
                endcase
            end
            default: dec_op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_ill = 1'b1;
        endcase
    end

    // During MULT, a_q is the shifting multiplicand and b_q the shifting multiplier.
    assign acc_next = acc + (b_q[0] ? a_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ready stays low through the done cycle, giving latency+1 per issued op.
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= dec_op;
                        ready <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= (dec_op == OP_MUL) ? S_MULT : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result  <= alu_res;
                    zero    <= (alu_res == '0);
                    illegal <= alu_ill;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                S_MULT: begin
                    acc <= acc_next;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result  <= acc_next;
                        zero    <= (acc_next == '0);
                        illegal <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu: latency-countdown reference model checked every cycle, plus directed literal cases.
module tb_mc_alu;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        ready, done, zero, illegal;
    logic [31:0] result;

    logic        start8, ready8, done8, zero8, illegal8;
    logic [7:0]  a8, b8, result8;
    logic        startn, readyn, donen, zeron, illegaln;
    logic [31:0] resultn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .ready(ready), .done(done), .result(result),
        .zero(zero), .illegal(illegal)
    );

    mc_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .aluop(aluop), .funct(funct),
        .a(a8), .b(b8), .ready(ready8), .done(done8), .result(result8),
        .zero(zero8), .illegal(illegal8)
    );

    mc_alu #(.WIDTH(32), .MUL_EN(1'b0)) dutn (
        .clk(clk), .rst(rst), .start(startn), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .ready(readyn), .done(donen), .result(resultn),
        .zero(zeron), .illegal(illegaln)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: what a 32-bit ALU with multiply must return, from the opcode table.
    function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output bit ill, output int lat);
        logic [63:0] prod;
        r = 32'd0;
        ill = 1'b0;
        lat = 1;
        if (op == 2'b00) r = x + y;
        else if (op == 2'b01) r = x - y;
        else if (op == 2'b10 && f == 6'b100000) r = x + y;
        else if (op == 2'b10 && f == 6'b100010) r = x - y;
        else if (op == 2'b10 && f == 6'b100100) r = x & y;
        else if (op == 2'b10 && f == 6'b100101) r = x | y;
        else if (op == 2'b10 && f == 6'b101010) r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        else if (op == 2'b10 && f == 6'b011000) begin
            prod = {32'd0, x} * {32'd0, y};
            r = prod[31:0];
            lat = 32;
        end else ill = 1'b1;
    endfunction

    logic        m_ready = 1'b1, m_done = 1'b0, m_zero = 1'b1, m_ill = 1'b0;
    logic [31:0] m_result = 32'd0, p_res = 32'd0;
    bit          p_ill = 1'b0;
    int          m_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ready = 1'b1; m_done = 1'b0; m_result = 32'd0; m_zero = 1'b1; m_ill = 1'b0; m_cnt = 0;
            end else begin
                m_done = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_done = 1'b1; m_result = p_res; m_zero = (p_res == 32'd0); m_ill = p_ill;
                    end
                end else if (!m_ready) begin
                    m_ready = 1'b1;
                end else if (start) begin
                    ref_op(aluop, funct, a, b, p_res, p_ill, m_cnt);
                    m_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("ready", ready, m_ready);
            chk("done", done, m_done);
            chk("result", result, m_result);
            chk("zero", zero, m_zero);
            chk("illegal", illegal, m_ill);
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input bit exp_ill,
                         input int exp_lat, input bit poke, input string nm);
        int cyc;
        cyc = 0;
        while (!m_ready && cyc < 100) begin @(negedge clk); cyc++; end
        aluop = op; funct = f; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) begin start = 1'b1; aluop = 2'b00; end
            if (poke && cyc == 6) start = 1'b0;
        end
        chk({nm, "_lat"}, cyc, exp_lat);
        chk({nm, "_res"}, result, exp);
        chk({nm, "_ill"}, illegal, exp_ill);
        chk({nm, "_zero"}, zero, exp == 32'd0);
    endtask

    task automatic do_aux(input bit sel8, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp,
                          input bit exp_ill, input int exp_lat, input string nm);
        int cyc;
        cyc = 0;
        while (!(sel8 ? ready8 : readyn) && cyc < 100) begin @(negedge clk); cyc++; end
        aluop = op; funct = f;
        if (sel8) begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
        else begin a = x; b = y; startn = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; startn = 1'b0;
        cyc = 0;
        while ((sel8 ? done8 : donen) !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk({nm, "_lat"}, cyc, exp_lat);
        chk({nm, "_res"}, sel8 ? {24'd0, result8} : resultn, exp);
        chk({nm, "_ill"}, sel8 ? illegal8 : illegaln, exp_ill);
        chk({nm, "_zero"}, sel8 ? zero8 : zeron, exp == 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    logic [5:0] ftab [8];

    initial begin
        ftab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                 6'b101010, 6'b011000, 6'b000000, 6'b111111};
        rst = 1'b1; start = 1'b0; aluop = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; startn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1); chk("rst_done", done, 0); chk("rst_result", result, 0);
        chk("rst_zero", zero, 1); chk("rst_illegal", illegal, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(2'b00, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 0, "add_wrap");
        do_op(2'b10, 6'b100010, 32'd5, 32'hFFFFFFFD, 32'd8, 0, 1, 0, "sub");
        do_op(2'b10, 6'b100100, 32'd5, 32'hFFFFFFFD, 32'd5, 0, 1, 0, "and");
        do_op(2'b10, 6'b100101, 32'd5, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, 1, 0, "or");
        do_op(2'b10, 6'b101010, 32'd5, 32'hFFFFFFFD, 32'd0, 0, 1, 0, "slt_pos");
        do_op(2'b10, 6'b101010, 32'hFFFFFFFD, 32'd5, 32'd1, 0, 1, 0, "slt_neg");
        do_op(2'b01, 6'd0, 32'd3, 32'd3, 32'd0, 0, 1, 0, "beq_sub");
        do_op(2'b10, 6'b011000, 32'h00010003, 32'h00020005, 32'h000B000F, 0, 32, 1, "mul");
        do_op(2'b11, 6'b100000, 32'd7, 32'd9, 32'd0, 1, 1, 0, "ill_aluop");
        do_op(2'b10, 6'b000000, 32'd7, 32'd9, 32'd0, 1, 1, 0, "ill_funct");
        do_op(2'b00, 6'd0, 32'd1, 32'd1, 32'd2, 0, 1, 0, "ill_clear");

        // Abort a multiply partway through.
        while (!m_ready) @(negedge clk);
        aluop = 2'b10; funct = 6'b011000; a = 32'd123; b = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready, 1); chk("abort_done", done, 0); chk("abort_result", result, 0);
        do_op(2'b00, 6'd0, 32'd2, 32'd2, 32'd4, 0, 1, 0, "add_after_abort");

        // Reset and start together: request dropped.
        while (!m_ready) @(negedge clk);
        rst = 1'b1; start = 1'b1; aluop = 2'b00; a = 32'd10; b = 32'd20;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_done", done, 0); chk("rst_start_ready", ready, 1);

        // Start held high: model tracks one accept every other cycle.
        aluop = 2'b00;
        for (int i = 0; i < 12; i++) begin
            start = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;

        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 2) != 0);
            aluop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) aluop = 2'b10;
            funct = ftab[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) funct = 6'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);

        do_aux(1'b0, 2'b10, 6'b011000, 32'd6, 32'd7, 32'd0, 1, 1, "nomul_ill");
        do_aux(1'b0, 2'b10, 6'b100000, 32'd6, 32'd7, 32'd13, 0, 1, "nomul_add");
        do_aux(1'b1, 2'b10, 6'b011000, 32'h10, 32'h10, 32'h00, 0, 8, "w8_mul_wrap");
        do_aux(1'b1, 2'b00, 6'd0, 32'h7F, 32'h01, 32'h80, 0, 1, "w8_add");
        do_aux(1'b1, 2'b10, 6'b011000, 32'hFF, 32'h03, 32'hFD, 0, 8, "w8_mul_neg");
        do_aux(1'b1, 2'b10, 6'b101010, 32'h80, 32'h7F, 32'h01, 0, 1, "w8_slt");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
